// File: rtl/l2_request_scheduler.sv
// Round-robin scheduler that shares one L2 port between the D-cache, I-cache and
// eviction write buffer, latching the winning request for the whole transaction.
module l2_request_scheduler #(
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic              e_write,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [LINE_W-1:0] e_wdata,
  output logic              d_resp,
  output logic              i_resp,
  output logic              e_resp,
  output logic [LINE_W-1:0] rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata,
  output logic              err_timeout
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [0:0]        state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        gnt_id_q, gnt_id_d;
  logic              op_write_q, op_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;

  logic [2:0]        pend;
  logic              hazard;
  logic              win_valid;
  logic [1:0]        win_id;
  logic              win_write;
  logic [ADDR_W-1:0] win_addr;
  logic [LINE_W-1:0] win_wdata;

  // A read+write requester counts as a write, so only pure reads can hit the EWB hazard.
  always_comb begin
    pend   = {e_write, i_read | i_write, d_read | d_write};
    hazard = e_write &&
             ((d_read && !d_write && (d_addr[ADDR_W-1:4] == e_addr[ADDR_W-1:4])) ||
              (i_read && !i_write && (i_addr[ADDR_W-1:4] == e_addr[ADDR_W-1:4])));
    win_valid = |pend;
    win_id    = 2'd0;
    if (hazard) begin
      win_id = 2'd2;
    end else begin
      case (rr_ptr_q)
        2'd1:    win_id = pend[1] ? 2'd1 : (pend[2] ? 2'd2 : 2'd0);
        2'd2:    win_id = pend[2] ? 2'd2 : (pend[0] ? 2'd0 : 2'd1);
        default: win_id = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
      endcase
    end
  end

  always_comb begin
    win_write = d_write;
    win_addr  = d_addr;
    win_wdata = d_wdata;
    case (win_id)
      2'd1: begin
        win_write = i_write;
        win_addr  = i_addr;
        win_wdata = i_wdata;
      end
      2'd2: begin
        win_write = 1'b1;
        win_addr  = e_addr;
        win_wdata = e_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d    = S_BUSY;
          gnt_id_d   = win_id;
          op_write_d = win_write;
          addr_d     = win_addr;
          wdata_d    = win_wdata;
          wait_cnt_d = 8'd0;
        end
      end
      S_BUSY: begin
        if (l2_resp) begin
          state_d  = S_IDLE;
          rr_ptr_d = (gnt_id_q == 2'd2) ? 2'd0 : gnt_id_q + 2'd1;
        end else begin
          // Saturate so a hung L2 never wraps the watchdog back below the threshold.
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
          if (wait_cnt_d >= TIMEOUT_C) err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= 2'd0;
      gnt_id_q   <= 2'd0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_id_q   <= gnt_id_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  logic busy;
  assign busy        = (state_q == S_BUSY);
  assign l2_read     = busy && !op_write_q;
  assign l2_write    = busy && op_write_q;
  assign l2_addr     = busy ? addr_q : '0;
  assign l2_wdata    = busy ? wdata_q : '0;
  assign d_resp      = busy && l2_resp && (gnt_id_q == 2'd0);
  assign i_resp      = busy && l2_resp && (gnt_id_q == 2'd1);
  assign e_resp      = busy && l2_resp && (gnt_id_q == 2'd2);
  assign rdata       = l2_rdata;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_l2_request_scheduler.sv
// Directed bench for l2_request_scheduler: reset, round-robin order, hazard override,
// request latching, read+write priority and the sticky watchdog (TIMEOUT=4).
module tb_l2_request_scheduler;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              d_read, d_write, i_read, i_write, e_write;
  logic [ADDR_W-1:0] d_addr, i_addr, e_addr;
  logic [LINE_W-1:0] d_wdata, i_wdata, e_wdata;
  logic              d_resp, i_resp, e_resp;
  logic [LINE_W-1:0] rdata;
  logic              l2_read, l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic              l2_resp;
  logic [LINE_W-1:0] l2_rdata;
  logic              err_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  l2_request_scheduler #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .e_write(e_write), .e_addr(e_addr), .e_wdata(e_wdata),
    .d_resp(d_resp), .i_resp(i_resp), .e_resp(e_resp), .rdata(rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    e_write = 0; e_addr = '0; e_wdata = '0;
    l2_resp = 0; l2_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic complete_txn();
    l2_resp = 1;
    step();
    l2_resp = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    #1;
    n_checks++;
    if ({l2_read, l2_write, d_resp, i_resp, e_resp, err_timeout} !== 6'b0)
      $display("[TB] FAIL reset_outputs: got %b expected 000000",
               {l2_read, l2_write, d_resp, i_resp, e_resp, err_timeout});
    else n_pass++;
    step();
    rst = 0;
    // First transaction completes so rr_ptr moves to 1 before the mid-busy reset.
    d_read = 1; d_addr = 16'h1230;
    step();
    n_checks++;
    if (l2_read !== 1'b1 || l2_addr !== 16'h1230)
      $display("[TB] FAIL reset_first_grant: got rd=%b addr=%h expected rd=1 addr=1230", l2_read, l2_addr);
    else n_pass++;
    complete_txn();
    n_checks++;
    if (l2_read !== 1'b0) $display("[TB] FAIL reset_bubble: got l2_read=%b expected 0", l2_read);
    else n_pass++;
    step();
    n_checks++;
    if (l2_read !== 1'b1) $display("[TB] FAIL reset_second_grant: got l2_read=%b expected 1", l2_read);
    else n_pass++;
    l2_resp = 1;
    rst = 1;
    #1;
    n_checks++;
    if (l2_read !== 1'b0 || d_resp !== 1'b0)
      $display("[TB] FAIL reset_mid_busy: got l2_read=%b d_resp=%b expected 0 0", l2_read, d_resp);
    else n_pass++;
    step();
    rst = 0; l2_resp = 0;
    i_read = 1; i_addr = 16'h2000;
    step();
    n_checks++;
    if (l2_addr !== 16'h1230 || l2_read !== 1'b1)
      $display("[TB] FAIL reset_rr_ptr: got addr=%h rd=%b expected addr=1230 rd=1 (D first)", l2_addr, l2_read);
    else n_pass++;
    complete_txn();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [ADDR_W-1:0] addr_tab [3];
    addr_tab = '{16'h1000, 16'h2000, 16'h3000};
    do_reset();
    d_read = 1; d_addr = addr_tab[0];
    i_read = 1; i_addr = addr_tab[1];
    e_write = 1; e_addr = addr_tab[2]; e_wdata = {4{32'hE0E0E0E0}};
    for (int k = 0; k < 6; k++) begin
      int exp_id;
      exp_id = k % 3;
      step();
      n_checks++;
      if (l2_addr !== addr_tab[exp_id] || l2_write !== (exp_id == 2) || l2_read !== (exp_id != 2))
        $display("[TB] FAIL rr_grant%0d: got addr=%h rd=%b wr=%b expected addr=%h id=%0d",
                 k, l2_addr, l2_read, l2_write, addr_tab[exp_id], exp_id);
      else n_pass++;
      step();
      step();
      l2_resp = 1;
      #1;
      n_checks++;
      if ({e_resp, i_resp, d_resp} !== (3'b001 << exp_id))
        $display("[TB] FAIL rr_resp%0d: got %b expected %b", k, {e_resp, i_resp, d_resp}, 3'b001 << exp_id);
      else n_pass++;
      step();
      l2_resp = 0;
      n_checks++;
      if ({l2_read, l2_write, e_resp, i_resp, d_resp} !== 5'b0)
        $display("[TB] FAIL rr_bubble%0d: got %b expected 00000", k, {l2_read, l2_write, e_resp, i_resp, d_resp});
      else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_hazard();
    do_reset();
    d_read = 1; d_addr = 16'h4A30;
    e_write = 1; e_addr = 16'h4A3C; e_wdata = {8{16'hABCD}};
    step();
    n_checks++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_addr !== 16'h4A3C)
      $display("[TB] FAIL hazard_ewb_first: got wr=%b rd=%b addr=%h expected wr=1 rd=0 addr=4a3c",
               l2_write, l2_read, l2_addr);
    else n_pass++;
    l2_resp = 1;
    #1;
    n_checks++;
    if ({e_resp, i_resp, d_resp} !== 3'b100)
      $display("[TB] FAIL hazard_ewb_resp: got %b expected 100", {e_resp, i_resp, d_resp});
    else n_pass++;
    step();
    l2_resp = 0; e_write = 0;
    step();
    n_checks++;
    if (l2_read !== 1'b1 || l2_addr !== 16'h4A30)
      $display("[TB] FAIL hazard_d_next: got rd=%b addr=%h expected rd=1 addr=4a30", l2_read, l2_addr);
    else n_pass++;
    complete_txn();
    // Different line: plain round robin from rr_ptr=0 lets D go first.
    do_reset();
    d_read = 1; d_addr = 16'h4A40;
    e_write = 1; e_addr = 16'h4A3C;
    step();
    n_checks++;
    if (l2_read !== 1'b1 || l2_addr !== 16'h4A40)
      $display("[TB] FAIL hazard_other_line: got rd=%b addr=%h expected rd=1 addr=4a40", l2_read, l2_addr);
    else n_pass++;
    complete_txn();
    clear_inputs();
  endtask

  task automatic test_latching();
    logic [LINE_W-1:0] pattern;
    pattern = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
    do_reset();
    i_read = 1; i_addr = 16'h0100;
    step();
    i_addr = 16'h0200;
    #1;
    n_checks++;
    if (l2_addr !== 16'h0100) $display("[TB] FAIL latch_addr_now: got %h expected 0100", l2_addr);
    else n_pass++;
    step();
    n_checks++;
    if (l2_addr !== 16'h0100 || l2_read !== 1'b1)
      $display("[TB] FAIL latch_addr_held: got addr=%h rd=%b expected 0100 1", l2_addr, l2_read);
    else n_pass++;
    l2_rdata = pattern;
    l2_resp = 1;
    #1;
    n_checks++;
    if (i_resp !== 1'b1 || rdata !== pattern || l2_addr !== 16'h0100)
      $display("[TB] FAIL latch_resp: got i_resp=%b rdata=%h addr=%h expected 1 %h 0100",
               i_resp, rdata, l2_addr, pattern);
    else n_pass++;
    step();
    l2_resp = 0;
    i_read = 0;
    step();
    // A stray l2_resp while idle must not produce any completion.
    l2_resp = 1;
    #1;
    n_checks++;
    if ({l2_read, l2_write, e_resp, i_resp, d_resp} !== 5'b0)
      $display("[TB] FAIL idle_resp_ignored: got %b expected 00000", {l2_read, l2_write, e_resp, i_resp, d_resp});
    else n_pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_read_write();
    logic [LINE_W-1:0] ones;
    ones = {8{16'h1111}};
    do_reset();
    d_read = 1; d_write = 1; d_addr = 16'h0010; d_wdata = ones;
    step();
    n_checks++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_wdata !== ones || l2_addr !== 16'h0010)
      $display("[TB] FAIL rw_as_write: got wr=%b rd=%b wdata=%h addr=%h expected 1 0 %h 0010",
               l2_write, l2_read, l2_wdata, l2_addr, ones);
    else n_pass++;
    complete_txn();
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    d_read = 1; d_addr = 16'h0040;
    step();
    step(); step(); step();
    n_checks++;
    if (err_timeout !== 1'b0) $display("[TB] FAIL timeout_early: got %b expected 0 after 3 busy cycles", err_timeout);
    else n_pass++;
    step();
    n_checks++;
    if (err_timeout !== 1'b1) $display("[TB] FAIL timeout_rise: got %b expected 1 after 4 busy cycles", err_timeout);
    else n_pass++;
    step(); step();
    l2_resp = 1;
    #1;
    n_checks++;
    if (d_resp !== 1'b1) $display("[TB] FAIL timeout_late_resp: got d_resp=%b expected 1", d_resp);
    else n_pass++;
    step();
    l2_resp = 0; d_read = 0;
    step(); step();
    n_checks++;
    if (err_timeout !== 1'b1) $display("[TB] FAIL timeout_sticky: got %b expected 1", err_timeout);
    else n_pass++;
    rst = 1;
    #1;
    n_checks++;
    if (err_timeout !== 1'b0) $display("[TB] FAIL timeout_cleared: got %b expected 0", err_timeout);
    else n_pass++;
    step();
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hazard();
    test_latching();
    test_read_write();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l2_request_scheduler.md
Name: l2_request_scheduler

Overview:
Schedules the single shared L2 port between three line-granularity requesters: D-cache (port 0), I-cache (port 1) and eviction write buffer, EWB (port 2).
- Grants one requester at a time using round-robin priority.
- Latches the winner's address, write data and operation for the whole transaction.
- Forces an EWB write-back ahead of any L1 read to the same line.
- Sits between the L1 caches/EWB and the L2 cache, replacing the fixed-priority data-first controller.

Parameters:
ADDR_W, 16, byte address width
LINE_W, 128, cache line width in bits
TIMEOUT, 255, busy cycles before err_timeout asserts (8-bit counter, 1..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
d_read, d_write  in  1 each  D-cache request
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write line
i_read, i_write  in  1 each  I-cache request
i_addr  in  ADDR_W  I-cache line address
i_wdata  in  LINE_W  I-cache write line
e_write  in  1  EWB write-back request (EWB never reads)
e_addr  in  ADDR_W  EWB line address
e_wdata  in  LINE_W  EWB write line
d_resp, i_resp, e_resp  out  1 each  per-requester completion
rdata  out  LINE_W  L2 read line, passthrough to all requesters
l2_read, l2_write  out  1 each  L2 command
l2_addr  out  ADDR_W  latched address
l2_wdata  out  LINE_W  latched write line
l2_resp  in  1  L2 completion
l2_rdata  in  LINE_W  L2 read data
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - state=S_IDLE, rr_ptr=0, wait counter=0.
  - All latches cleared.
  - l2_read=l2_write=0, all *_resp=0, err_timeout=0.
  - An in-flight L2 transaction is abandoned; L2 is expected to be reset together with this block.
- Requests are level-held by requesters until their resp is seen.
  - A requester with both read and write high is treated as a write.
- States:
  - S_IDLE: evaluate pending requests. If any are pending, latch the winner's id, op, addr and wdata, then go to S_BUSY next cycle. l2_* are deasserted in S_IDLE.
  - S_BUSY: drive l2_read/l2_write (exactly one), l2_addr and l2_wdata from the latches only, ignoring live inputs. Stay until l2_resp=1.
    - In the l2_resp cycle: the granted requester's resp=1 combinationally in that same cycle, and rdata=l2_rdata.
    - Next state is S_IDLE; rr_ptr=(granted_id+1) mod 3.
- Minimum latency: request seen in S_IDLE at cycle N -> l2 command at N+1 -> resp at the l2_resp cycle.
  - There is a mandatory one-cycle S_IDLE bubble between transactions, so a requester's dropped request is never re-granted.
- Arbitration in S_IDLE:
  - Hazard override: if e_write=1 and any pending L1 read has addr[ADDR_W-1:4]==e_addr[ADDR_W-1:4], EWB wins regardless of rr_ptr. rr_ptr still updates to 0 after that grant.
  - Otherwise: the first pending requester scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3) wins.
  - No pending requests: stay in S_IDLE, rr_ptr unchanged.
- rdata always mirrors l2_rdata; only the resp strobes qualify it.
- Watchdog:
  - The 8-bit counter clears on entry to S_BUSY and increments each S_BUSY cycle without l2_resp.
  - When it reaches TIMEOUT, err_timeout sets and stays set until rst.
  - The FSM keeps waiting; it never aborts a transaction.
- An l2_resp seen in S_IDLE is ignored; no resp is generated.
- Live requester input changes during S_BUSY have no effect on l2_* outputs.

Test Plan:
1. Reset mid-busy: d_read at addr 0x1230, rst pulses in S_BUSY -> same-cycle l2_read=0, d_resp=0; after release, FSM in S_IDLE, rr_ptr=0.
2. All three requesting continuously, L2 responding 2 cycles after each command -> grant order D, I, E, D, I, E; each resp 1 cycle wide; an idle cycle between l2 commands.
3. Hazard override: rr_ptr=0, d_read addr 0x4A30 and e_write addr 0x4A3C together -> EWB granted first (l2_write=1, l2_addr=0x4A3C); D-cache granted next.
4. Latching: i_read addr 0x0100 granted, then i_addr changed to 0x0200 during S_BUSY -> l2_addr stays 0x0100 until l2_resp; i_resp=1 with rdata=l2_rdata=0xDEAD...BEEF.
5. d_read=d_write=1, addr 0x0010, wdata 0x1111...1111 -> l2_write=1, l2_read=0, l2_wdata=0x1111...1111.
6. TIMEOUT=4, l2_resp withheld -> err_timeout rises after 4 busy cycles and stays 1 after a later l2_resp completes the transfer, until rst.
